// File: rtl/pattern_scan_pkg.sv
// Shared types and default widths for the pattern scan controller.
package pattern_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH    = 16;
  localparam int DEF_PATTERN_WIDTH = 3;
  localparam int DEF_COUNT_WIDTH   = $clog2(DEF_DATA_WIDTH + 1);

endpackage

// File: rtl/pattern_scan_controller_if.sv
// Word-in / count-out handshake bundle plus pattern config and status.
interface pattern_scan_controller_if
  import pattern_scan_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int PATTERN_WIDTH = DEF_PATTERN_WIDTH,
  parameter int COUNT_WIDTH   = $clog2(DATA_WIDTH + 1)
);
  logic                     cfg_write;
  logic [PATTERN_WIDTH-1:0] cfg_pattern;
  logic                     in_valid;
  logic [DATA_WIDTH-1:0]    in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic [COUNT_WIDTH-1:0]   out_count;
  logic                     out_ready;
  logic                     busy;

  modport master (
    output cfg_write, cfg_pattern,
    output in_valid, in_data,
    input  in_ready,
    input  out_valid, out_count,
    output out_ready,
    input  busy
  );

  modport slave (
    input  cfg_write, cfg_pattern,
    input  in_valid, in_data,
    output in_ready,
    output out_valid, out_count,
    input  out_ready,
    output busy
  );
endinterface

// File: rtl/seq_window_matcher.sv
// Sliding bit window with fill tracking; flags a hit on the post-shift window.
module seq_window_matcher #(
  parameter int PATTERN_WIDTH = 3
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     bit_valid,
  input  logic                     bit_in,
  input  logic [PATTERN_WIDTH-1:0] pattern,
  input  logic                     flush,
  output logic                     hit
);
  localparam int FW = $clog2(PATTERN_WIDTH + 1);
  localparam logic [FW-1:0] FULL = FW'(PATTERN_WIDTH);

  logic [PATTERN_WIDTH-1:0] win;
  logic [PATTERN_WIDTH-1:0] win_nx;
  logic [FW-1:0]            fill;
  logic [FW-1:0]            fill_nx;

  always_comb begin
    win_nx  = {win[PATTERN_WIDTH-2:0], bit_in};
    fill_nx = (fill == FULL) ? FULL : fill + 1'b1;
  end

  // Partial windows right after a flush must never count.
  assign hit = bit_valid
             && (win_nx == pattern)
             && (fill_nx == FULL);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      win  <= '0;
      fill <= '0;
    end else if (flush) begin
      win  <= '0;
      fill <= '0;
    end else if (bit_valid) begin
      win  <= win_nx;
      fill <= fill_nx;
    end
  end
endmodule

// File: rtl/pattern_scan_controller.sv
// Word-to-bit sequencer counting pattern hits per word.
// PATTERN_SCAN_CARRY_EN: keep the window across words so boundary hits count.
module pattern_scan_controller
  import pattern_scan_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int PATTERN_WIDTH = DEF_PATTERN_WIDTH,
  parameter int COUNT_WIDTH   = $clog2(DATA_WIDTH + 1)
) (
  input logic clock,
  input logic clear,
  pattern_scan_controller_if.slave bus
);
  localparam int BW = $clog2(DATA_WIDTH);

  state_t                   state;
  state_t                   state_nx;
  logic [DATA_WIDTH-1:0]    shreg;
  logic [BW-1:0]            bit_cnt;
  logic [COUNT_WIDTH-1:0]   match_cnt;
  logic [PATTERN_WIDTH-1:0] pattern;
  logic                     accept;
  logic                     cfg_take;
  logic                     bit_valid;
  logic                     last_bit;
  logic                     flush;
  logic                     hit;

  assign accept    = (state == IDLE) && bus.in_valid;
  assign cfg_take  = (state == IDLE) && bus.cfg_write;
  assign bit_valid = (state == SCAN);
  assign last_bit  = (bit_cnt == '0);

`ifdef PATTERN_SCAN_CARRY_EN
  assign flush = cfg_take;
`else
  assign flush = accept;
`endif

  seq_window_matcher #(
    .PATTERN_WIDTH(PATTERN_WIDTH)
  ) u_matcher (
    .clock    (clock),
    .clear    (clear),
    .bit_valid(bit_valid),
    .bit_in   (shreg[DATA_WIDTH-1]),
    .pattern  (pattern),
    .flush    (flush),
    .hit      (hit)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_nx = SCAN;
      SCAN:    if (last_bit)      state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE) && !clear;
    bus.out_valid = (state == DONE);
    bus.busy      = (state != IDLE);
    bus.out_count = (state == DONE) ? match_cnt : '0;
  end

  // Pattern is written at the acceptance edge, so it governs that word.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      pattern   <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      match_cnt <= '0;
    end else begin
      if (cfg_take) pattern <= bus.cfg_pattern;
      if (accept) begin
        shreg     <= bus.in_data;
        bit_cnt   <= BW'(DATA_WIDTH - 1);
        match_cnt <= '0;
      end else if (bit_valid) begin
        shreg   <= {shreg[DATA_WIDTH-2:0], 1'b0};
        bit_cnt <= bit_cnt - 1'b1;
        if (hit) match_cnt <= match_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pattern_scan_controller.sv
// Directed bench for pattern_scan_controller (16-bit words, 3-bit pattern).
module tb_pattern_scan_controller;
  import pattern_scan_pkg::*;

  localparam int DW = 16;
  localparam int PW = 3;
  localparam int CW = $clog2(DW + 1);

  logic clock = 1'b0;
  logic clear;
  int   total = 0;
  int   bad   = 0;

  pattern_scan_controller_if #(
    .DATA_WIDTH(DW), .PATTERN_WIDTH(PW), .COUNT_WIDTH(CW)
  ) bus ();

  pattern_scan_controller #(
    .DATA_WIDTH(DW), .PATTERN_WIDTH(PW), .COUNT_WIDTH(CW)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg(input logic [PW-1:0] p);
    bus.cfg_write   = 1'b1;
    bus.cfg_pattern = p;
    step();
    bus.cfg_write   = 1'b0;
  endtask

  task automatic start_word(input logic [DW-1:0] d);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid; in_ready must stay low.
  task automatic wait_valid(output int n, output logic ok);
    n  = 0;
    ok = 1'b1;
    while (!bus.out_valid && n < 40) begin
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) ok = 1'b0;
      step();
      n++;
    end
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) ok = 1'b0;
  endtask

  task automatic run_word(input logic [DW-1:0] d,
                          input int exp,
                          input string tag);
    int   n;
    logic ok;
    start_word(d);
    wait_valid(n, ok);
    check({tag, "_latency"}, n, DW);
    check({tag, "_count"}, bus.out_count, exp);
    check({tag, "_ready_low"}, ok, 1);
    step();
    check({tag, "_valid_drop"}, bus.out_valid, 0);
  endtask

  initial begin
    int   n;
    logic ok;
    logic seen;
    int   carry_exp;

`ifdef PATTERN_SCAN_CARRY_EN
    carry_exp = 1;
`else
    carry_exp = 0;
`endif

    clear           = 1'b1;
    bus.cfg_write   = 1'b0;
    bus.cfg_pattern = '0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_count", bus.out_count, 0);
    check("rst_busy", bus.busy, 0);
    step();
    step();
    clear = 1'b0;
    #1;
    check("idle_in_ready", bus.in_ready, 1);
    step();

    cfg(3'b101);
    run_word(16'hA5A5, 4, "a5a5");

    cfg(3'b101);
    run_word(16'h5555, 7, "w5555");
    run_word(16'hFFFF, 0, "wffff");

    cfg(3'b101);
    run_word(16'h0002, 0, "w0002");
    run_word(16'h8000, carry_exp, "w8000");

    cfg(3'b101);
    bus.out_ready = 1'b0;
    start_word(16'hA5A5);
    wait_valid(n, ok);
    check("bp_latency", n, DW);
    check("bp_count", bus.out_count, 4);
    for (int i = 0; i < 5; i++) begin
      bus.cfg_write   = 1'b1;
      bus.cfg_pattern = 3'b111;
      step();
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_count", bus.out_count, 4);
      check("bp_hold_ready", bus.in_ready, 0);
    end
    bus.cfg_write = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("bp_release_valid", bus.out_valid, 0);
    check("bp_release_ready", bus.in_ready, 1);
    run_word(16'hA5A5, 4, "bp_cfg_ignored");

    bus.cfg_write   = 1'b1;
    bus.cfg_pattern = 3'b111;
    start_word(16'hFFFF);
    bus.cfg_write   = 1'b0;
    wait_valid(n, ok);
    check("samecyc_latency", n, DW);
    check("samecyc_count", bus.out_count, 14);
    step();

    start_word(16'hA5A5);
    repeat (6) step();
    clear = 1'b1;
    #1;
    check("clr_in_ready", bus.in_ready, 0);
    check("clr_busy", bus.busy, 0);
    check("clr_out_valid", bus.out_valid, 0);
    step();
    clear = 1'b0;
    #1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid !== 1'b0) seen = 1'b1;
      step();
    end
    check("clr_no_valid", seen, 0);
    check("clr_ready_after", bus.in_ready, 1);
    run_word(16'h0000, 14, "clr_pattern_zero");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
